// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with shadowed digit capture, leading-zero blanking and frame pulse.
// Optional macro SEG7_HEX_EN: codes 10..15 decode to hex letters instead of a dash.
`timescale 1ns/1ps
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      blank_lz,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;

  logic                    w_tick;
  logic                    w_last;
  logic [3:0]              w_cur_digit;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  logic                    w_zero_run;
  logic [7:0]              w_seg_c;
  logic [NUM_DIGITS-1:0]   w_an_c;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
`ifdef SEG7_HEX_EN
      4'd10:   return 7'b0001000;
      4'd11:   return 7'b1100000;
      4'd12:   return 7'b0110001;
      4'd13:   return 7'b1000010;
      4'd14:   return 7'b0110000;
      default: return 7'b0111000;
`else
      default: return 7'b1111110;
`endif
    endcase
  endfunction

  assign w_tick = en && (r_presc == PRESC_MAX);
  assign w_last = (r_idx == IDX_MAX);

  // Select the active shadow digit; the zero run walks down from the most significant digit.
  always_comb begin
    w_cur_digit = 4'd0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    w_zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_sh_digits[4*i +: 4] == 4'd0);
      if (IW'(i) == r_idx) begin
        w_cur_digit = r_sh_digits[4*i +: 4];
        w_cur_dp    = r_sh_dp[i];
        w_cur_blank = blank_lz && w_zero_run && (i != 0);
      end
    end
  end

  assign w_seg_c = {~w_cur_dp, w_cur_blank ? 7'h7F : f_decode(w_cur_digit)};
  assign w_an_c  = ~(NUM_DIGITS'(1) << r_idx);

  // Scan state, shadow capture and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      an          <= '1;
      seg         <= 8'hFF;
      frame_done  <= 1'b0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_idx <= w_last ? '0 : r_idx + IW'(1);
      end
      if (w_tick && w_last) begin
        r_sh_digits <= digits;
        r_sh_dp     <= dp;
      end
      an         <= w_an_c;
      seg        <= w_seg_c;
      frame_done <= w_tick && w_last;
    end else begin
      an         <= '1;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a 4-digit instance and a 1-digit instance checked against a frame-arithmetic model.
`timescale 1ns/1ps
module tb_seg7_scan_driver;
  localparam int unsigned N = 4;
  localparam int unsigned R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  logic        en1 = 1'b1;
  logic        bl1 = 1'b0;
  logic [3:0]  d1 = '0;
  logic        p1 = 1'b0;
  logic [7:0]  seg1;
  logic        an1;
  logic        fd1;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .dp(dp), .blank_lz(blank_lz),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) u1 (
    .clk(clk), .rst(rst), .en(en1), .digits(d1), .dp(p1), .blank_lz(bl1),
    .seg(seg1), .an(an1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fd;
    logic       an1;
    logic [7:0] seg1;
    logic       fd1;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Model state: enabled cycles since reset, plus the frame snapshot currently on display.
  int         t = 0;
  int         sd[N];
  logic [3:0] sdp = '0;
  int         sd1 = 0;
  logic       sdp1 = 1'b0;

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
`ifdef SEG7_HEX_EN
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
`else
      default: return 7'b1111110;
`endif
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected response for the upcoming rising edge, given the inputs now applied.
  task automatic push();
    exp_t e;
    int   slot, dig;
    logic blank;
    if (rst) begin
      t = 0;
      for (int k = 0; k < N; k++) sd[k] = 0;
      sdp = '0; sd1 = 0; sdp1 = 1'b0;
      e = '{an: 4'hF, seg: 8'hFF, fd: 1'b0, an1: 1'b1, seg1: 8'hFF, fd1: 1'b0};
    end else begin
      if (en) begin
        slot = t / R;
        dig  = slot % N;
        blank = 1'b0;
        if (blank_lz && dig > 0) begin
          blank = 1'b1;
          for (int k = dig; k < N; k++) if (sd[k] != 0) blank = 1'b0;
        end
        e.an  = ~(4'(1) << dig);
        e.seg = {~sdp[dig], blank ? 7'h7F : seg_of(sd[dig])};
        e.fd  = ((t + 1) % (R * N)) == 0;
        if (e.fd) begin
          for (int k = 0; k < N; k++) sd[k] = int'(digits[4*k +: 4]);
          sdp = dp;
        end
        t++;
      end else begin
        e.an = 4'hF; e.seg = 8'hFF; e.fd = 1'b0;
      end
      e.an1  = 1'b0;
      e.seg1 = {~sdp1, seg_of(sd1)};
      e.fd1  = 1'b1;
      sd1  = int'(d1);
      sdp1 = p1;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input logic r_, input logic e_, input logic [15:0] d_,
                     input logic [3:0] p_, input logic b_);
    @(negedge clk);
    rst = r_; en = e_; digits = d_; dp = p_; blank_lz = b_;
    d1 = 4'($urandom); p1 = 1'($urandom);
    push();
  endtask

  task automatic run(input int n, input logic e_, input logic [15:0] d_,
                     input logic [3:0] p_, input logic b_);
    for (int i = 0; i < n; i++) cyc(1'b0, e_, d_, p_, b_);
  endtask

  task automatic check_reset_now();
    #1;
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'hFF);
    check("async_fd", 32'(frame_done), 32'h0);
    check("async_an1", 32'(an1), 32'h1);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("an", 32'(an), 32'(mon_e.an));
      check("seg", 32'(seg), 32'(mon_e.seg));
      check("frame_done", 32'(frame_done), 32'(mon_e.fd));
      check("an1", 32'(an1), 32'(mon_e.an1));
      check("seg1", 32'(seg1), 32'(mon_e.seg1));
      check("frame_done1", 32'(fd1), 32'(mon_e.fd1));
    end
  end

  initial begin
    cyc(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    check_reset_now();
    cyc(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    run(32, 1'b1, 16'h1234, 4'h0, 1'b0);
    run(32, 1'b1, 16'h0050, 4'b0010, 1'b1);
    run(16, 1'b1, 16'h0050, 4'b0010, 1'b0);
    run(24, 1'b1, 16'h1111, 4'h0, 1'b0);
    run(24, 1'b1, 16'h2222, 4'h0, 1'b0);
    run(10, 1'b1, 16'h5678, 4'h3, 1'b0);
    run(10, 1'b0, 16'h5678, 4'h3, 1'b0);
    run(22, 1'b1, 16'h5678, 4'h3, 1'b0);
    run(32, 1'b1, 16'h00B0, 4'h0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] rd;
      rd = (i % 40 < 20) ? 16'($urandom) : 16'($urandom_range(0, 255));
      run(1 + ($urandom % 3), ($urandom % 8) != 0, rd, 4'($urandom), 1'($urandom));
    end
    run(22, 1'b1, 16'h9876, 4'h5, 1'b0);
    cyc(1'b1, 1'b1, 16'h9876, 4'h5, 1'b0);
    check_reset_now();
    cyc(1'b1, 1'b1, 16'h9876, 4'h5, 1'b0);
    cyc(1'b1, 1'b1, 16'h9876, 4'h5, 1'b0);
    run(40, 1'b1, 16'h4321, 4'hA, 1'b1);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot; legal range >= 1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable; 0 freezes scanning and blanks the display.
REQ-006 SHALL have port digits  input  4*NUM_DIGITS  packed digit codes; digit i at [4i+3:4i], digit 0 rightmost.
REQ-007 SHALL have port dp  input  NUM_DIGITS  per-digit decimal point request, 1 = lit.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL have port seg  output  8  segment drive {DP,A,B,C,D,E,F,G}, active-low, registered.
REQ-010 SHALL have port an  output  NUM_DIGITS  digit anode select, active-low, one-hot-low or all ones, registered.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan frame, registered.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 while en=1; tick = en AND prescaler==REFRESH_DIV-1; on tick the prescaler SHALL return to 0.
REQ-013 On tick, digit index SHALL advance idx -> idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-014 On tick with idx==NUM_DIGITS-1, shadow registers SHALL capture digits and dp, and frame_done SHALL be 1 in the following cycle only.
REQ-015 Display SHALL use only the shadow registers, so input changes mid-frame do not tear the display.
REQ-016 Each cycle with en=1: an <= all ones except bit idx = 0; seg <= decode(shadow digit idx) with seg[7] = ~shadow_dp[idx] (1-cycle latency from idx).
REQ-017 Decode, A-G bits: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-018 Codes 10..15 SHALL decode to dash 1111110 unless SEG7_HEX_EN is defined (REQ-024).
REQ-019 With blank_lz=1, digit i (i>0) SHALL show A-G = 1111111 when shadow digits i..NUM_DIGITS-1 are all 0; digit 0 is never blanked; DP still follows shadow dp.
REQ-020 With en=0: prescaler, idx and shadow SHALL hold; an <= all ones; seg <= 8'hFF; frame_done <= 0. Scanning SHALL resume from the held state when en returns to 1.
REQ-021 With NUM_DIGITS=1, idx SHALL stay 0, and every tick SHALL be a frame end.

Reset
REQ-022 While rst=1 (asynchronously): prescaler=0, idx=0, shadow digits=0, shadow dp=0, an=all ones, seg=8'hFF, frame_done=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no frame_done pulse; after release, the first enabled cycle starts the digit-0 slot with prescaler 0.

Configuration
REQ-024 Macro SEG7_HEX_EN defined: codes 10..15 SHALL decode A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; undefined: dash per REQ-018. No other behaviour SHALL differ.

Verification (NUM_DIGITS=4, REFRESH_DIV=4 unless stated)
REQ-025 Reset release, en=1, digits=16'h1234, dp=0 -> first frame shows shadow zeros (an 1110,1101,1011,0111, each for 4 cycles, seg=8'b10000001); frame_done pulses once; next frame shows 4,3,2,1 on an 1110..0111.
REQ-026 digits=16'h0050, blank_lz=1, dp=4'b0010 -> digit3,digit2 seg=8'hFF; digit1 seg=8'b00100100; digit0 seg=8'b10000001; blank_lz=0 -> digit3 seg=8'b10000001.
REQ-027 digits changed mid-frame from 16'h1111 to 16'h2222 -> remainder of current frame still shows 1 (8'b11001111); next frame shows 2 (8'b10010010).
REQ-028 en dropped for 10 cycles during digit-2 slot, prescaler=2 -> an=1111, seg=8'hFF throughout; after en=1, digit-2 slot completes its remaining 2 cycles then advances to digit 3.
REQ-029 digit code 4'hB: without SEG7_HEX_EN seg=8'b11111110; with SEG7_HEX_EN seg=8'b11100000; rst pulsed mid-frame -> an=1111, seg=8'hFF immediately, no frame_done.
REQ-030 NUM_DIGITS=1, REFRESH_DIV=1 -> an=0 every enabled cycle, frame_done high every cycle after the first tick, shadow reloaded every cycle.
